// File: rtl/sad_pkg.sv
// Shared types, defaults and helpers for the SAD trigger sequencer.
//
// Contents:
//    sad_state_t        - sequencer state encoding
//    FILL_CYCLES        - pipeline fill length for the default configuration
//    calc_fill_cycles() - fill length for any reference length / latency
//    cnt_width()        - width of the shared fill/holdoff down-counters
package sad_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      ARMED,
      TRIG,
      HOLDOFF,
      DONE
   } sad_state_t;

   localparam int DEF_REF_SAMPLES  = 32;
   localparam int DEF_PIPE_LATENCY = 5;
   localparam int FILL_CYCLES      = DEF_REF_SAMPLES + DEF_PIPE_LATENCY - 1;

   // Cycles the datapath needs before every window it reports on holds
   // only samples taken after arming.
   function automatic int calc_fill_cycles(input int ref_samples, input int pipe_latency);
      return ref_samples + pipe_latency - 1;
   endfunction

   // The fill counter is loaded with the fill length itself, and the
   // holdoff counter with up to 2^holdoff_width-2 or ref_samples-1, so the
   // counter must span the largest of those.
   function automatic int cnt_width(input int fill_len, input int holdoff_width,
                                    input int ref_samples);
      int span;
      span = 1 << holdoff_width;
      if (fill_len + 1 > span) span = fill_len + 1;
      if (ref_samples > span) span = ref_samples;
      return (span > 2) ? $clog2(span) : 1;
   endfunction

endpackage

// File: rtl/sad_trig_counter.sv
// Saturating trigger status counter with sticky "triggered" flag.
//
// Ports:
//    clk_adc  - clock
//    reset    - asynchronous active-high reset
//    clear    - zero count and flag (an increment in the same cycle still lands)
//    incr     - one trigger accepted this cycle
//    count    - triggers since last clear, holds at all-ones
//    flag     - at least one trigger since last clear
module sad_trig_counter #(
   parameter int pWIDTH = 8
) (
   input  logic              clk_adc,
   input  logic              reset,
   input  logic              clear,
   input  logic              incr,
   output logic [pWIDTH-1:0] count,
   output logic              flag
);

   // A clear that coincides with a trigger restarts the count at one rather
   // than dropping that trigger, so software never misses the newest event.
   always_ff @(posedge clk_adc or posedge reset) begin
      if (reset) begin
         count <= '0;
         flag  <= 1'b0;
      end else if (clear) begin
         count <= incr ? pWIDTH'(1) : '0;
         flag  <= incr;
      end else if (incr) begin
         flag <= 1'b1;
         if (count != '1) count <= count + pWIDTH'(1);
      end
   end

endmodule

// File: rtl/sad_trigger_ctrl.sv
// Sequencer for the SAD compare datapath: arms and flushes the engine,
// waits out the pipeline fill, turns sad_match into a stretched trigger,
// enforces a post-trigger holdoff and keeps trigger status.
//
// Ports:
//    clk_adc            - sole clock
//    reset              - asynchronous active-high reset
//    armed_and_ready    - capture armed (level); low returns to IDLE
//    multiple_triggers  - 1 re-arms after holdoff, 0 stops in DONE
//    holdoff_cycles     - post-trigger ignore window, 0 means pREF_SAMPLES
//    clear_status       - pulse, clears triggered / trigger_count
//    sad_match          - registered datapath compare flag
//    sad_flush          - clears datapath accumulators and valid pipeline
//    sad_enable         - datapath accumulate enable
//    trigger            - qualified trigger pulse, pTRIG_CYCLES wide
//    triggered          - sticky, set by any trigger since last clear
//    trigger_count      - saturating trigger count since last clear
//    busy               - sequencer not in IDLE
module sad_trigger_ctrl
   import sad_pkg::*;
#(
   parameter int pREF_SAMPLES   = 32,
   parameter int pPIPE_LATENCY  = 5,
   parameter int pTRIG_CYCLES   = 1,
   parameter int pCOUNT_WIDTH   = 8,
   parameter int pHOLDOFF_WIDTH = 16
) (
   input  logic                      clk_adc,
   input  logic                      reset,
   input  logic                      armed_and_ready,
   input  logic                      multiple_triggers,
   input  logic [pHOLDOFF_WIDTH-1:0] holdoff_cycles,
   input  logic                      clear_status,
   input  logic                      sad_match,
   output logic                      sad_flush,
   output logic                      sad_enable,
   output logic                      trigger,
   output logic                      triggered,
   output logic [pCOUNT_WIDTH-1:0]   trigger_count,
   output logic                      busy
);

   localparam int FILL_LEN = calc_fill_cycles(pREF_SAMPLES, pPIPE_LATENCY);
   localparam int CNT_W    = cnt_width(FILL_LEN, pHOLDOFF_WIDTH, pREF_SAMPLES);
   localparam int TRIG_W   = (pTRIG_CYCLES > 1) ? $clog2(pTRIG_CYCLES) : 1;

   localparam logic [CNT_W-1:0]  FILL_LOAD = CNT_W'(FILL_LEN);
   localparam logic [CNT_W-1:0]  REF_HOLD  = CNT_W'(pREF_SAMPLES - 1);
   localparam logic [TRIG_W-1:0] TRIG_LOAD = TRIG_W'(pTRIG_CYCLES - 1);

   sad_state_t         state;
   logic [CNT_W-1:0]   fill_cnt;
   logic [CNT_W-1:0]   hold_cnt;
   logic [TRIG_W-1:0]  trig_cnt;
   logic [CNT_W-1:0]   hold_load;
   logic               trig_fire;

   // A zero holdoff setting means "one reference length", which keeps a
   // sliding window from re-matching on the same samples that just fired.
   always_comb begin
      hold_load = REF_HOLD;
      if (holdoff_cycles != '0) hold_load = CNT_W'(holdoff_cycles) - CNT_W'(1);
   end

   // Only a match seen while ARMED and still armed counts as a trigger; a
   // dropped arm in the same cycle wins.
   assign trig_fire = (state == ARMED) && armed_and_ready && sad_match;

   // Sequencer. The fill counter is loaded with the full fill length and the
   // transition to ARMED happens on the edge where it reaches zero, so FILL
   // lasts exactly FILL_LEN cycles. Losing armed_and_ready aborts from any
   // state, cutting a trigger pulse short, while leaving status untouched.
   always_ff @(posedge clk_adc or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         fill_cnt   <= '0;
         hold_cnt   <= '0;
         trig_cnt   <= '0;
         sad_flush  <= 1'b1;
         sad_enable <= 1'b0;
         trigger    <= 1'b0;
         busy       <= 1'b0;
      end else if (!armed_and_ready) begin
         state      <= IDLE;
         sad_flush  <= 1'b1;
         sad_enable <= 1'b0;
         trigger    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state      <= FILL;
               fill_cnt   <= FILL_LOAD;
               sad_flush  <= 1'b0;
               sad_enable <= 1'b1;
               busy       <= 1'b1;
            end
            FILL: begin
               if ((fill_cnt == CNT_W'(1)) || (fill_cnt == '0)) begin
                  state    <= ARMED;
                  fill_cnt <= '0;
               end else begin
                  fill_cnt <= fill_cnt - CNT_W'(1);
               end
            end
            ARMED: begin
               if (sad_match) begin
                  state    <= TRIG;
                  trigger  <= 1'b1;
                  trig_cnt <= TRIG_LOAD;
               end
            end
            TRIG: begin
               if (trig_cnt == '0) begin
                  state    <= HOLDOFF;
                  trigger  <= 1'b0;
                  hold_cnt <= hold_load;
               end else begin
                  trig_cnt <= trig_cnt - TRIG_W'(1);
               end
            end
            HOLDOFF: begin
               if (hold_cnt == '0) begin
                  if (multiple_triggers) begin
                     state <= ARMED;
                  end else begin
                     state      <= DONE;
                     sad_enable <= 1'b0;
                  end
               end else begin
                  hold_cnt <= hold_cnt - CNT_W'(1);
               end
            end
            DONE: begin
               sad_enable <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               sad_flush  <= 1'b1;
               sad_enable <= 1'b0;
               trigger    <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   sad_trig_counter #(
      .pWIDTH (pCOUNT_WIDTH)
   ) u_status (
      .clk_adc (clk_adc),
      .reset   (reset),
      .clear   (clear_status),
      .incr    (trig_fire),
      .count   (trigger_count),
      .flag    (triggered)
   );

endmodule
